miner_dispatch: RTL and testbench
=================================

# miner_dispatch

Nonce-range scheduler that shares a search job across `NUM_CORES` SHA3-256 miner cores. It sits between the Avalon register front end and the array of core wrappers. It hands each idle core a contiguous chunk of 2^`CHUNK_LOG2` nonces in round-robin order, and stops the array on the first solution, on a host halt, or on nonce-space exhaustion. It reports the result with a one-cycle interrupt pulse.

## Interface
- `NUM_CORES`, 4 — number of core wrappers, 1..16.
- `NONCE_W`, 64 — nonce width.
- `CHUNK_LOG2`, 24 — log2 of nonces per dispatched chunk, less than `NONCE_W`.
- `clk` in 1 — clock.
- `rst` in 1 — reset, synchronous, active-high.
- `job_start` in 1 — pulse: begin a job at `base_nonce`.
- `job_halt` in 1 — pulse: abort the running job.
- `base_nonce` in `NONCE_W` — first nonce of the job; sampled on `job_start`.
- `core_start` out `NUM_CORES` — one-hot pulse: the core begins its chunk.
- `core_nonce` out `NONCE_W` — chunk start nonce; valid with `core_start`.
- `core_abort` out 1 — level: all busy cores stop immediately.
- `core_done` in `NUM_CORES` — per-core pulse: chunk finished, or the core stopped after abort.
- `core_found` in `NUM_CORES` — qualifies `core_done`: a solution was found.
- `core_solution` in `NUM_CORES`*`NONCE_W` — per-core solution; valid with `core_done`&`core_found`.
- `busy` out 1 — a job is active (states RUN and DRAIN).
- `found` out 1 — the last job ended with a solution.
- `exhausted` out 1 — the last job ended because the nonce space was used up.
- `solution` out `NONCE_W` — winning nonce.
- `found_core` out 4 — index of the winning core.
- `next_nonce` out `NONCE_W` — next undispatched nonce (progress).
- `irq` out 1 — one-cycle pulse on entry to DONE.

## Operation
- **States.** IDLE, RUN, DRAIN, DONE.
- **Per-core tracking.** One `core_busy` bit per core. It is set on `core_start` and cleared on `core_done`.
- **IDLE or DONE + `job_start`:**
  - `next_nonce`←`base_nonce`.
  - `found`, `exhausted`, `solution` and `found_core` are cleared.
  - `stop_issue`←0.
  - Go to RUN.
- **`job_start` in RUN or DRAIN:** ignored.
- **Dispatch in RUN (when `stop_issue`=0):**
  - Each cycle, at most one idle core receives `core_start`.
  - The round-robin pointer selects the first idle core at or after `ptr`; `ptr` then advances to that index+1, mod `NUM_CORES`.
  - `core_nonce`=`next_nonce`; `next_nonce` += 2^`CHUNK_LOG2`.
- **Wrap-around.** If that addition carries out of `NONCE_W`:
  - The chunk is still dispatched.
  - `stop_issue`←1 and `exhausted`←1.
  - `next_nonce` holds its wrapped value.
- **Solution.** `core_done`&`core_found` on any core in RUN:
  - Latch `solution` and `found_core`, set `found`, set `stop_issue`, go to DRAIN.
  - If several cores report a find in the same cycle, the lowest index wins.
  - Non-winning dones in that cycle are ignored, apart from clearing their busy bits.
- **Halt.** `job_halt` in RUN: go to DRAIN with `found`=0.
  - `exhausted` keeps its current value.
  - `job_halt` in any other state is ignored.
- **Exhaustion.** RUN with `stop_issue`=1 and all cores idle, no find: go to DONE.
- **DRAIN:**
  - `core_abort`=1 and no dispatch.
  - Finds reported during DRAIN are ignored; the first winner is kept.
  - When all busy bits are 0, go to DONE.
- **Done in the same cycle as a find.** A core reporting `core_done` becomes idle next cycle. The arbiter uses the registered busy bits, so the earliest re-dispatch to that core is the cycle after its done.
- **DONE:** `busy`=0. All results hold until the next `job_start`.
- **Reset value of every output is 0.** Reset also clears `ptr`, the busy bits and the FSM state (to IDLE).
- **Reset mid-job.** The cores share `rst`, so no abort handshake takes place.

## Timing
- `job_start` at cycle T:
  - `busy`=1 at T+1.
  - First `core_start` at T+1, to core 0 with `core_nonce`=`base_nonce`.
  - With all cores idle, core k is started at T+1+k.
- All outputs are registered.
- A winning `core_done` at cycle T gives `found`/`solution` at T+1 and `core_abort` from T+1.
- DRAIN to DONE: one cycle after the last busy bit clears.
- `irq` is high for exactly the first cycle of DONE.
- No `core_start` is issued in the same cycle as, or after, the detection of a find or halt.

## Structure
- Shared package `miner_pkg` holds:
  - the state enum `dispatch_state_t` (IDLE/RUN/DRAIN/DONE);
  - `NONCE_W`;
  - the nonce type `nonce_t`.
- One sub-module: `miner_rr_pick`. It takes `NUM_CORES` request bits and `ptr`, and combinationally returns a one-hot grant, the grant index and a valid flag. It is reused by later result-collection logic.
- Estimated size: 200–300 lines.

## Test plan
- **Dispatch order.** `NUM_CORES`=4, `CHUNK_LOG2`=4, `base_nonce`=0x100.
  - Expect `core_start` 0001, 0010, 0100, 1000 with `core_nonce` 0x100, 0x110, 0x120, 0x130 on consecutive cycles.
  - Then `core_done` on core 2 → core 2 restarts at 0x140.
- **Find and drain.**
  - `core_done`+`core_found` on core 1, solution 0x1234.
  - Expect `core_abort` next cycle.
  - After the other cores return done: `irq` pulse, `found`=1, `solution`=0x1234, `found_core`=1.
- **Simultaneous finds.**
  - Cores 3 and 1 report a find in the same cycle with different solutions.
  - Expect `found_core`=1 with core 1's solution.
- **Wrap-around.**
  - `base_nonce`=2^64−32, `CHUNK_LOG2`=4.
  - Expect exactly two dispatches, then `exhausted`=1, `found`=0, and `irq` once all cores are done.
- **Halt and restart.**
  - `job_halt` mid-RUN → DRAIN, then DONE with `found`=0.
  - `job_start` while in DRAIN is ignored.
  - `job_start` in DONE clears the results and restarts at the new `base_nonce`.
- **Reset mid-job.** Assert `rst` during RUN → all outputs 0 on the next cycle and the FSM is in IDLE.

Source files
------------

// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types and constants for the miner dispatch slice
package miner_pkg;

    localparam int NONCE_W = 64;

    typedef logic [NONCE_W-1:0] nonce_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dispatch_state_t;

endpackage

// File: rtl/miner_rr_pick.sv
// rtl/miner_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module miner_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic [N-1:0] grant,
    output logic [3:0]   idx,
    output logic         valid
);

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = 4'(j);
            end
        end
    end

endmodule

// File: rtl/miner_dispatch.sv
// rtl/miner_dispatch.sv - nonce-range scheduler sharing one search job across miner cores
module miner_dispatch #(
    parameter int NUM_CORES  = 4,
    parameter int NONCE_W    = 64,
    parameter int CHUNK_LOG2 = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           job_start,
    input  logic                           job_halt,
    input  logic [NONCE_W-1:0]             base_nonce,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NONCE_W-1:0]             core_nonce,
    output logic                           core_abort,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_found,
    input  logic [NUM_CORES*NONCE_W-1:0]   core_solution,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [NONCE_W-1:0]             solution,
    output logic [3:0]                     found_core,
    output logic [NONCE_W-1:0]             next_nonce,
    output logic                           irq
);

    import miner_pkg::*;

    // One extra bit so the chunk addition exposes its carry-out (nonce-space wrap).
    localparam logic [NONCE_W:0] CHUNK = {{NONCE_W{1'b0}}, 1'b1} << CHUNK_LOG2;

    dispatch_state_t        state;
    logic [NUM_CORES-1:0]   busy_bits;
    logic [3:0]             ptr;
    logic                   stop_issue;

    logic [NUM_CORES-1:0]   hit;
    logic [NUM_CORES-1:0]   pick_grant;
    logic [3:0]             pick_idx;
    logic                   pick_valid;
    logic [NUM_CORES-1:0]   win_grant;
    logic [3:0]             win_idx;
    logic                   win_valid;
    logic [NONCE_W-1:0]     win_sol;

    logic                   start_ok;
    logic                   do_issue;
    logic [NUM_CORES-1:0]   issue_grant;
    logic [3:0]             issue_idx;
    logic [3:0]             ptr_next;
    logic [NONCE_W-1:0]     issue_nonce;
    logic [NONCE_W:0]       issue_sum;

    assign hit = core_done & core_found;

    // Dispatch arbiter works from the registered busy bits only.
    miner_rr_pick #(.N(NUM_CORES)) u_pick (
        .req   (~busy_bits),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A fixed pointer of zero turns the same picker into a lowest-index-wins selector.
    miner_rr_pick #(.N(NUM_CORES)) u_win (
        .req   (hit),
        .ptr   (4'd0),
        .grant (win_grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Mux the winning core's solution out of the packed bus.
    always_comb begin
        win_sol = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (win_grant[i]) begin
                win_sol = core_solution[i*NONCE_W +: NONCE_W];
            end
        end
    end

    // A job start dispatches core 0 on the same edge; in RUN the arbiter picks,
    // but never alongside a find or a halt.
    always_comb begin
        start_ok    = ((state == ST_IDLE) || (state == ST_DONE)) && job_start;
        do_issue    = start_ok ||
                      ((state == ST_RUN) && !stop_issue && !win_valid && !job_halt && pick_valid);
        issue_grant = start_ok ? NUM_CORES'(1) : pick_grant;
        issue_idx   = start_ok ? 4'd0 : pick_idx;
        issue_nonce = start_ok ? base_nonce : next_nonce;
        issue_sum   = {1'b0, issue_nonce} + CHUNK;
        ptr_next    = (issue_idx == 4'(NUM_CORES - 1)) ? 4'd0 : issue_idx + 4'd1;
    end

    // Job FSM, busy tracking, chunk issue and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy_bits  <= '0;
            ptr        <= '0;
            stop_issue <= 1'b0;
            core_start <= '0;
            core_nonce <= '0;
            core_abort <= 1'b0;
            busy       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            solution   <= '0;
            found_core <= '0;
            next_nonce <= '0;
            irq        <= 1'b0;
        end else begin
            core_start <= '0;
            irq        <= 1'b0;
            busy_bits  <= (busy_bits & ~core_done) | (do_issue ? issue_grant : '0);

            if (do_issue) begin
                core_start <= issue_grant;
                core_nonce <= issue_nonce;
                next_nonce <= issue_sum[NONCE_W-1:0];
                ptr        <= ptr_next;
                if (issue_sum[NONCE_W]) begin
                    stop_issue <= 1'b1;
                    exhausted  <= 1'b1;
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (job_start) begin
                        found      <= 1'b0;
                        solution   <= '0;
                        found_core <= '0;
                        stop_issue <= issue_sum[NONCE_W];
                        exhausted  <= issue_sum[NONCE_W];
                        busy       <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (win_valid) begin
                        found      <= 1'b1;
                        solution   <= win_sol;
                        found_core <= win_idx;
                        stop_issue <= 1'b1;
                        core_abort <= 1'b1;
                        state      <= ST_DRAIN;
                    end else if (job_halt) begin
                        stop_issue <= 1'b1;
                        core_abort <= 1'b1;
                        state      <= ST_DRAIN;
                    end else if (stop_issue && (busy_bits == '0)) begin
                        busy  <= 1'b0;
                        irq   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    if (busy_bits == '0) begin
                        core_abort <= 1'b0;
                        busy       <= 1'b0;
                        irq        <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miner_dispatch.sv
// tb/tb_miner_dispatch.sv - directed self-checking bench for miner_dispatch
module tb_miner_dispatch;

    localparam int NC = 4;
    localparam int NW = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              job_start = 1'b0;
    logic              job_halt = 1'b0;
    logic [NW-1:0]     base_nonce = '0;
    logic [NC-1:0]     core_start;
    logic [NW-1:0]     core_nonce;
    logic              core_abort;
    logic [NC-1:0]     core_done = '0;
    logic [NC-1:0]     core_found = '0;
    logic [NC*NW-1:0]  core_solution = '0;
    logic              busy;
    logic              found;
    logic              exhausted;
    logic [NW-1:0]     solution;
    logic [3:0]        found_core;
    logic [NW-1:0]     next_nonce;
    logic              irq;

    int passed = 0;
    int total  = 0;

    miner_dispatch #(.NUM_CORES(NC), .NONCE_W(NW), .CHUNK_LOG2(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .job_start     (job_start),
        .job_halt      (job_halt),
        .base_nonce    (base_nonce),
        .core_start    (core_start),
        .core_nonce    (core_nonce),
        .core_abort    (core_abort),
        .core_done     (core_done),
        .core_found    (core_found),
        .core_solution (core_solution),
        .busy          (busy),
        .found         (found),
        .exhausted     (exhausted),
        .solution      (solution),
        .found_core    (found_core),
        .next_nonce    (next_nonce),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        // Reset
        step(); step();
        chk("rst_core_start", 64'(core_start), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_next_nonce", next_nonce, 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        rst = 1'b0;
        step();

        // Dispatch order
        base_nonce = 64'h100; job_start = 1'b1; step(); job_start = 1'b0;
        chk("d0_busy", 64'(busy), 64'h1);
        chk("d0_start", 64'(core_start), 64'h1);
        chk("d0_nonce", core_nonce, 64'h100);
        step();
        chk("d1_start", 64'(core_start), 64'h2);
        chk("d1_nonce", core_nonce, 64'h110);
        step();
        chk("d2_start", 64'(core_start), 64'h4);
        chk("d2_nonce", core_nonce, 64'h120);
        step();
        chk("d3_start", 64'(core_start), 64'h8);
        chk("d3_nonce", core_nonce, 64'h130);
        chk("d3_next", next_nonce, 64'h140);
        step();
        chk("all_busy_nostart", 64'(core_start), 64'h0);
        core_done = 4'b0100; step(); core_done = '0;
        chk("done_cycle_nostart", 64'(core_start), 64'h0);
        step();
        chk("redispatch_start", 64'(core_start), 64'h4);
        chk("redispatch_nonce", core_nonce, 64'h140);

        // Find and drain
        core_done = 4'b0010; core_found = 4'b0010;
        core_solution[1*NW +: NW] = 64'h1234;
        step();
        core_done = '0; core_found = '0;
        chk("find_abort", 64'(core_abort), 64'h1);
        chk("find_found", 64'(found), 64'h1);
        chk("find_solution", solution, 64'h1234);
        chk("find_core", 64'(found_core), 64'h1);
        chk("find_nostart", 64'(core_start), 64'h0);
        core_done = 4'b1101; core_found = 4'b0001;
        core_solution[0*NW +: NW] = 64'hdead;
        step();
        core_done = '0; core_found = '0;
        chk("drain_keep_solution", solution, 64'h1234);
        chk("drain_no_irq_yet", 64'(irq), 64'h0);
        step();
        chk("drain_done_irq", 64'(irq), 64'h1);
        chk("drain_done_busy", 64'(busy), 64'h0);
        chk("drain_done_abort", 64'(core_abort), 64'h0);
        step();
        chk("irq_one_cycle", 64'(irq), 64'h0);
        chk("done_hold_found", 64'(found), 64'h1);
        chk("done_hold_core", 64'(found_core), 64'h1);

        // Simultaneous finds: lowest index wins
        base_nonce = 64'h0; job_start = 1'b1; step(); job_start = 1'b0;
        chk("restart_clear_found", 64'(found), 64'h0);
        step(); step(); step();
        chk("sim_all_started", 64'(core_start), 64'h8);
        core_done = 4'b1010; core_found = 4'b1010;
        core_solution[1*NW +: NW] = 64'haaaa;
        core_solution[3*NW +: NW] = 64'hbbbb;
        step();
        core_done = '0; core_found = '0;
        chk("sim_core", 64'(found_core), 64'h1);
        chk("sim_solution", solution, 64'haaaa);
        core_done = 4'b0101; step(); core_done = '0;
        step();
        chk("sim_irq", 64'(irq), 64'h1);

        // Wrap-around of the nonce space
        base_nonce = 64'hFFFF_FFFF_FFFF_FFE0; job_start = 1'b1; step(); job_start = 1'b0;
        chk("wrap_d0_nonce", core_nonce, 64'hFFFF_FFFF_FFFF_FFE0);
        chk("wrap_d0_exh", 64'(exhausted), 64'h0);
        step();
        chk("wrap_d1_start", 64'(core_start), 64'h2);
        chk("wrap_d1_nonce", core_nonce, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("wrap_exhausted", 64'(exhausted), 64'h1);
        chk("wrap_next", next_nonce, 64'h0);
        step();
        chk("wrap_no_third", 64'(core_start), 64'h0);
        core_done = 4'b0011; step(); core_done = '0;
        chk("wrap_busy_before_done", 64'(busy), 64'h1);
        step();
        chk("wrap_irq", 64'(irq), 64'h1);
        chk("wrap_found", 64'(found), 64'h0);
        chk("wrap_exh_hold", 64'(exhausted), 64'h1);

        // Halt and restart
        base_nonce = 64'h500; job_start = 1'b1; step(); job_start = 1'b0;
        chk("halt_start_clear_exh", 64'(exhausted), 64'h0);
        step();
        chk("halt_d1_nonce", core_nonce, 64'h510);
        job_halt = 1'b1; step(); job_halt = 1'b0;
        chk("halt_abort", 64'(core_abort), 64'h1);
        chk("halt_nostart", 64'(core_start), 64'h0);
        chk("halt_found", 64'(found), 64'h0);
        base_nonce = 64'h900; job_start = 1'b1; step(); job_start = 1'b0;
        chk("drain_start_ignored_next", next_nonce, 64'h520);
        chk("drain_start_ignored_cs", 64'(core_start), 64'h0);
        core_done = 4'b0011; step(); core_done = '0;
        step();
        chk("halt_irq", 64'(irq), 64'h1);
        chk("halt_done_found", 64'(found), 64'h0);
        job_start = 1'b1; step(); job_start = 1'b0;
        chk("restart_start", 64'(core_start), 64'h1);
        chk("restart_nonce", core_nonce, 64'h900);
        chk("restart_busy", 64'(busy), 64'h1);

        // Reset mid-job
        step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst_busy", 64'(busy), 64'h0);
        chk("mrst_core_start", 64'(core_start), 64'h0);
        chk("mrst_core_nonce", core_nonce, 64'h0);
        chk("mrst_next", next_nonce, 64'h0);
        chk("mrst_abort", 64'(core_abort), 64'h0);
        base_nonce = 64'h40; job_start = 1'b1; step(); job_start = 1'b0;
        chk("mrst_idle_start", 64'(core_start), 64'h1);
        chk("mrst_idle_nonce", core_nonce, 64'h40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
